// File: rtl/ssp_apb_driver_pkg.sv
// Shared definitions for the SSP bus-side driver: widths, depths and FSM state codes.
package ssp_apb_driver_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned SSP_RX_FIFO_DEPTH = 4;
  localparam int unsigned STATUS_CNT_W      = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_RWAIT = 3'd4
  } drv_state_e;

  // Index width that stays legal for a depth of one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssp_byte_fifo.sv
// Byte FIFO with first-word-fall-through head; push and pop may coincide at any occupancy.
module ssp_byte_fifo
  import ssp_apb_driver_pkg::*;
#(
  parameter int unsigned DEPTH = SSP_RX_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head_data,
  output logic              head_valid,
  output logic              empty
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop     = pop && (count != '0);
  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);
  assign empty      = (count == '0);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !do_pop)      count <= count + OCC_W'(1);
      else if (!push && do_pop) count <= count - OCC_W'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ssp_apb_driver.sv
// Bus-side SSP driver: streams source bytes into the SSP TX FIFO and burst-drains the RX FIFO to a sink.
module ssp_apb_driver
  import ssp_apb_driver_pkg::*;
#(
  parameter int unsigned RX_FIFO_DEPTH = SSP_RX_FIFO_DEPTH,
  parameter int unsigned CNT_W         = STATUS_CNT_W
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              SRC_VALID,
  input  logic [BYTE_W-1:0] SRC_DATA,
  output logic              SRC_READY,
  output logic              SNK_VALID,
  output logic [BYTE_W-1:0] SNK_DATA,
  input  logic              SNK_READY,
  output logic              PSEL,
  output logic              PWRITE,
  output logic [BYTE_W-1:0] PWDATA,
  input  logic [BYTE_W-1:0] PRDATA,
  input  logic              SSPTXINTR,
  input  logic              SSPRXINTR,
  output logic              BUSY,
  output logic [CNT_W-1:0]  TXCNT,
  output logic [CNT_W-1:0]  RXCNT
);

  localparam int unsigned BURST_W = clog2_min1(RX_FIFO_DEPTH);

  drv_state_e         state_q;
  drv_state_e         state_d;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] burst_d;
  logic               accept_c;
  logic               psel_d;
  logic               pwrite_d;
  logic               rd_pipe_q;
  logic               buf_empty;

  // Next-state and registered-bus-output decode.
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    accept_c = 1'b0;
    psel_d   = 1'b0;
    pwrite_d = PWRITE;
    case (state_q)
      ST_IDLE: begin
        if (SSPRXINTR && buf_empty) begin
          state_d  = ST_READ;
          burst_d  = '0;
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
        end else if (SRC_VALID && !SSPTXINTR) begin
          accept_c = 1'b1;
          state_d  = ST_WRITE;
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      ST_READ: begin
        if (burst_q == BURST_W'(RX_FIFO_DEPTH - 1)) begin
          state_d = ST_RWAIT;
        end else begin
          burst_d  = burst_q + BURST_W'(1);
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
        end
      end
      ST_RWAIT: if (rd_pipe_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Bus outputs, read-issue pipe and status counters; the pipe marks the cycle PRDATA is valid.
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      PSEL      <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rd_pipe_q <= 1'b0;
      TXCNT     <= '0;
      RXCNT     <= '0;
    end else begin
      PSEL      <= psel_d;
      PWRITE    <= pwrite_d;
      rd_pipe_q <= PSEL && !PWRITE;
      if (accept_c) begin
        PWDATA <= SRC_DATA;
        TXCNT  <= TXCNT + CNT_W'(1);
      end
      if (rd_pipe_q) RXCNT <= RXCNT + CNT_W'(1);
    end
  end

  // Ready is masked during reset so a waiting source is never told it was taken.
  assign SRC_READY = accept_c && !CLEAR;
  assign BUSY      = (state_q != ST_IDLE) || !buf_empty;

  ssp_byte_fifo #(
    .DEPTH(RX_FIFO_DEPTH)
  ) u_snk_buf (
    .clk        (PCLK),
    .clear      (CLEAR),
    .push       (rd_pipe_q),
    .push_data  (PRDATA),
    .pop        (SNK_READY),
    .head_data  (SNK_DATA),
    .head_valid (SNK_VALID),
    .empty      (buf_empty)
  );

endmodule

// File: tb/tb_ssp_apb_driver.sv
// Directed cycle table plus a randomized loopback run against a behavioural SSP model.
module tb_ssp_apb_driver;

  localparam int N_LOOP    = 40;
  localparam int SSP_DEPTH = 4;

  logic        PCLK = 1'b0;
  logic        CLEAR;
  logic        SRC_VALID;
  logic [7:0]  SRC_DATA;
  logic        SRC_READY;
  logic        SNK_VALID;
  logic [7:0]  SNK_DATA;
  logic        SNK_READY;
  logic        PSEL;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        SSPTXINTR;
  logic        SSPRXINTR;
  logic        BUSY;
  logic [15:0] TXCNT;
  logic [15:0] RXCNT;

  always #5 PCLK = ~PCLK;

  ssp_apb_driver dut (
    .PCLK      (PCLK),
    .CLEAR     (CLEAR),
    .SRC_VALID (SRC_VALID),
    .SRC_DATA  (SRC_DATA),
    .SRC_READY (SRC_READY),
    .SNK_VALID (SNK_VALID),
    .SNK_DATA  (SNK_DATA),
    .SNK_READY (SNK_READY),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .SSPTXINTR (SSPTXINTR),
    .SSPRXINTR (SSPRXINTR),
    .BUSY      (BUSY),
    .TXCNT     (TXCNT),
    .RXCNT     (RXCNT)
  );

  typedef struct {
    logic        clr, sv;
    logic [7:0]  sd;
    logic        sr, ti, ri;
    logic [7:0]  pr;
    logic        psel, pw;
    logic [7:0]  pwd;
    logic        rdy, vld;
    logic [7:0]  sdat;
    logic        busy;
    logic [15:0] tx, rx;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // One clock cycle: inputs applied after the rising edge, outputs checked at the falling edge.
  task automatic v(input int clr, sv, sd, sr, ti, ri, pr,
                   input int psel, pw, pwd, rdy, vld, sdat, busy, tx, rx);
    vec_t e;
    e.clr = (clr != 0);  e.sv = (sv != 0);  e.sd = 8'(sd);
    e.sr = (sr != 0);    e.ti = (ti != 0);  e.ri = (ri != 0);  e.pr = 8'(pr);
    e.psel = (psel != 0); e.pw = (pw != 0); e.pwd = 8'(pwd);
    e.rdy = (rdy != 0);  e.vld = (vld != 0); e.sdat = 8'(sdat);
    e.busy = (busy != 0); e.tx = 16'(tx);   e.rx = 16'(rx);
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  logic [7:0] src_b [N_LOOP];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] pr_pend;
  int         src_idx, wr_idx, rx_idx, timer, cyc;

  initial begin
    CLEAR = 1'b1; SRC_VALID = 1'b0; SRC_DATA = 8'h00; SNK_READY = 1'b0;
    PRDATA = 8'h00; SSPTXINTR = 1'b0; SSPRXINTR = 1'b0;

    //     clr sv  sd   sr ti ri  pr    psel pw pwd  rdy vld sdat busy tx rx
    v(1,0,'h00,0,0,0,'h00, 0,0,'h00,0,0,'h00,0,0,0);  // reset
    v(0,0,'h00,0,0,0,'h00, 0,0,'h00,0,0,'h00,0,0,0);
    v(0,1,'h94,0,0,0,'h00, 0,0,'h00,1,0,'h00,0,0,0);  // TX stream
    v(0,1,'h0F,0,0,0,'h00, 1,1,'h94,0,0,'h00,1,1,0);
    v(0,1,'h0F,0,0,0,'h00, 0,1,'h94,0,0,'h00,1,1,0);
    v(0,1,'h0F,0,0,0,'h00, 0,1,'h94,1,0,'h00,0,1,0);
    v(0,1,'h51,0,0,0,'h00, 1,1,'h0F,0,0,'h00,1,2,0);
    v(0,1,'h51,0,0,0,'h00, 0,1,'h0F,0,0,'h00,1,2,0);
    v(0,1,'h51,0,0,0,'h00, 0,1,'h0F,1,0,'h00,0,2,0);
    v(0,1,'h24,0,0,0,'h00, 1,1,'h51,0,0,'h00,1,3,0);
    v(0,1,'h24,0,0,0,'h00, 0,1,'h51,0,0,'h00,1,3,0);
    v(0,1,'h24,0,0,0,'h00, 0,1,'h51,1,0,'h00,0,3,0);
    v(0,0,'h00,0,0,0,'h00, 1,1,'h24,0,0,'h00,1,4,0);
    v(0,0,'h00,0,0,0,'h00, 0,1,'h24,0,0,'h00,1,4,0);
    v(0,0,'h00,0,0,0,'h00, 0,1,'h24,0,0,'h00,0,4,0);
    v(0,1,'hC3,0,1,0,'h00, 0,1,'h24,0,0,'h00,0,4,0);  // TX back-pressure
    v(0,1,'hC3,0,1,0,'h00, 0,1,'h24,0,0,'h00,0,4,0);
    v(0,1,'hC3,0,0,0,'h00, 0,1,'h24,1,0,'h00,0,4,0);
    v(0,0,'h00,0,0,0,'h00, 1,1,'hC3,0,0,'h00,1,5,0);
    v(0,0,'h00,0,0,0,'h00, 0,1,'hC3,0,0,'h00,1,5,0);
    v(0,0,'h00,0,0,0,'h00, 0,1,'hC3,0,0,'h00,0,5,0);
    v(0,0,'h00,0,0,1,'h00, 0,1,'hC3,0,0,'h00,0,5,0);  // RX burst, RXINTR drops mid-burst
    v(0,0,'h00,0,0,1,'h00, 1,0,'hC3,0,0,'h00,1,5,0);
    v(0,0,'h00,0,0,0,'hA1, 1,0,'hC3,0,0,'h00,1,5,0);
    v(0,0,'h00,0,0,0,'hA2, 1,0,'hC3,0,1,'hA1,1,5,1);
    v(0,0,'h00,0,0,0,'hA3, 1,0,'hC3,0,1,'hA1,1,5,2);
    v(0,0,'h00,0,0,0,'hA4, 0,0,'hC3,0,1,'hA1,1,5,3);
    v(0,0,'h00,0,0,0,'h00, 0,0,'hC3,0,1,'hA1,1,5,4);
    v(0,0,'h00,1,0,0,'h00, 0,0,'hC3,0,1,'hA1,1,5,4);  // drain sink
    v(0,0,'h00,1,0,0,'h00, 0,0,'hC3,0,1,'hA2,1,5,4);
    v(0,0,'h00,1,0,0,'h00, 0,0,'hC3,0,1,'hA3,1,5,4);
    v(0,0,'h00,1,0,0,'h00, 0,0,'hC3,0,1,'hA4,1,5,4);
    v(0,0,'h00,0,0,0,'h00, 0,0,'hC3,0,0,'h00,0,5,4);
    v(0,1,'h5A,0,0,1,'h00, 0,0,'hC3,0,0,'h00,0,5,4);  // RX wins over TX
    v(0,1,'h5A,0,0,1,'h00, 1,0,'hC3,0,0,'h00,1,5,4);
    v(0,1,'h5A,0,0,1,'hB1, 1,0,'hC3,0,0,'h00,1,5,4);
    v(0,1,'h5A,0,0,1,'hB2, 1,0,'hC3,0,1,'hB1,1,5,5);
    v(0,1,'h5A,0,0,1,'hB3, 1,0,'hC3,0,1,'hB1,1,5,6);
    v(0,1,'h5A,0,0,1,'hB4, 0,0,'hC3,0,1,'hB1,1,5,7);
    v(0,1,'h5A,0,0,1,'h00, 0,0,'hC3,1,1,'hB1,1,5,8);  // buffer full: TX proceeds, no burst
    v(0,0,'h00,0,0,1,'h00, 1,1,'h5A,0,1,'hB1,1,6,8);
    v(0,0,'h00,0,0,1,'h00, 0,1,'h5A,0,1,'hB1,1,6,8);
    v(0,0,'h00,0,0,1,'h00, 0,1,'h5A,0,1,'hB1,1,6,8);
    v(0,0,'h00,0,0,1,'h00, 0,1,'h5A,0,1,'hB1,1,6,8);
    v(0,0,'h00,1,0,1,'h00, 0,1,'h5A,0,1,'hB1,1,6,8);  // sink drains, then second burst
    v(0,0,'h00,1,0,1,'h00, 0,1,'h5A,0,1,'hB2,1,6,8);
    v(0,0,'h00,1,0,1,'h00, 0,1,'h5A,0,1,'hB3,1,6,8);
    v(0,0,'h00,1,0,1,'h00, 0,1,'h5A,0,1,'hB4,1,6,8);
    v(0,0,'h00,1,0,1,'h00, 0,1,'h5A,0,0,'h00,0,6,8);
    v(0,0,'h00,1,0,1,'h00, 1,0,'h5A,0,0,'h00,1,6,8);
    v(1,1,'h77,0,0,1,'h00, 0,0,'h00,0,0,'h00,0,0,0);  // CLEAR mid-burst
    v(0,0,'h00,0,0,0,'h99, 0,0,'h00,0,0,'h00,0,0,0);
    v(0,0,'h00,0,0,0,'h00, 0,0,'h00,0,0,'h00,0,0,0);

    foreach (vecs[i]) begin
      @(posedge PCLK); #1;
      CLEAR = vecs[i].clr; SRC_VALID = vecs[i].sv; SRC_DATA = vecs[i].sd;
      SNK_READY = vecs[i].sr; SSPTXINTR = vecs[i].ti; SSPRXINTR = vecs[i].ri;
      PRDATA = vecs[i].pr;
      @(negedge PCLK);
      chk("psel",      i, 32'(PSEL),      32'(vecs[i].psel));
      chk("pwrite",    i, 32'(PWRITE),    32'(vecs[i].pw));
      chk("pwdata",    i, 32'(PWDATA),    32'(vecs[i].pwd));
      chk("src_ready", i, 32'(SRC_READY), 32'(vecs[i].rdy));
      chk("snk_valid", i, 32'(SNK_VALID), 32'(vecs[i].vld));
      if (vecs[i].vld) chk("snk_data", i, 32'(SNK_DATA), 32'(vecs[i].sdat));
      chk("busy",      i, 32'(BUSY),      32'(vecs[i].busy));
      chk("txcnt",     i, 32'(TXCNT),     32'(vecs[i].tx));
      chk("rxcnt",     i, 32'(RXCNT),     32'(vecs[i].rx));
    end

    // Loopback: SSP model moves TX FIFO bytes into its RX FIFO at >=16 PCLK per byte.
    for (int i = 0; i < N_LOOP; i++) src_b[i] = 8'($urandom);
    src_idx = 0; wr_idx = 0; rx_idx = 0; timer = 16; cyc = 0; pr_pend = 8'h00;
    @(posedge PCLK); #1;
    CLEAR = 1'b1;
    @(posedge PCLK); #1;
    CLEAR = 1'b0;
    while (rx_idx < N_LOOP && cyc < 20000) begin
      @(posedge PCLK); #1;
      PRDATA    = pr_pend;
      SSPTXINTR = (txq.size() >= SSP_DEPTH);
      SSPRXINTR = (rxq.size() >= SSP_DEPTH);
      SRC_VALID = (src_idx < N_LOOP) && ($urandom_range(3) != 0);
      SRC_DATA  = (src_idx < N_LOOP) ? src_b[src_idx] : 8'h00;
      SNK_READY = ($urandom_range(2) != 0);
      @(negedge PCLK);
      if (SRC_VALID && SRC_READY) src_idx++;
      if (SNK_VALID && SNK_READY) begin
        chk("loop_snk_data", rx_idx, 32'(SNK_DATA), 32'(src_b[rx_idx]));
        rx_idx++;
      end
      if (PSEL && PWRITE) begin
        chk("loop_tx_room", wr_idx, 32'(txq.size() < SSP_DEPTH), 32'd1);
        if (wr_idx < N_LOOP) chk("loop_pwdata", wr_idx, 32'(PWDATA), 32'(src_b[wr_idx]));
        else chk("loop_extra_write", wr_idx, 32'(wr_idx), 32'(N_LOOP - 1));
        txq.push_back(PWDATA);
        wr_idx++;
      end
      if (PSEL && !PWRITE) begin
        chk("loop_rx_nonempty", rx_idx, 32'(rxq.size() != 0), 32'd1);
        if (rxq.size() != 0) pr_pend = rxq.pop_front();
      end
      if (timer > 0) timer--;
      else if (txq.size() != 0 && rxq.size() < SSP_DEPTH) begin
        rxq.push_back(txq.pop_front());
        timer = 16 + int'($urandom_range(7));
      end
      cyc++;
    end
    if (rx_idx < N_LOOP) begin
      n_vec++;
      n_err++;
      $display("FAIL loop_timeout: received %0d bytes, expected %0d", rx_idx, N_LOOP);
    end
    SRC_VALID = 1'b0;
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    chk("loop_txcnt", 0, 32'(TXCNT), 32'(N_LOOP));
    chk("loop_rxcnt", 0, 32'(RXCNT), 32'(N_LOOP));
    chk("loop_busy",  0, 32'(BUSY),  32'd0);
    chk("loop_psel",  0, 32'(PSEL),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
